// File: rtl/alu_result_stage_if.sv
// Handshake and payload bundle between the ALU and the EX/MEM result stage.
// The slave modport is the stage itself. The master modport is the side that
// drives the ALU inputs and consumes the stage outputs.
interface alu_result_stage_if #(
  parameter int BUS   = 8,
  parameter int RADDR = 5
);
  // upstream side (ALU -> stage)
  logic             in_valid;
  logic             in_ready;
  logic [BUS-1:0]   sout;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             negative;
  logic [BUS-1:0]   store_data;
  logic [RADDR-1:0] dest_reg;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [2:0]       branch_cond;
  logic             flags_we;
  logic             trap_en;
  logic             flush;

  // downstream side (stage -> memory access)
  logic             out_valid;
  logic             out_ready;
  logic [BUS-1:0]   out_result;
  logic [BUS-1:0]   out_store_data;
  logic [RADDR-1:0] out_dest_reg;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic             branch_taken;
  logic             trap;
  logic [3:0]       flags;

  modport slave (
    input  in_valid, sout, zero, cout, overflow, negative, store_data,
           dest_reg, reg_write, mem_read, mem_write, branch_cond, flags_we,
           trap_en, flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_dest_reg,
           out_reg_write, out_mem_read, out_mem_write, branch_taken, trap,
           flags
  );

  modport master (
    output in_valid, sout, zero, cout, overflow, negative, store_data,
           dest_reg, reg_write, mem_read, mem_write, branch_cond, flags_we,
           trap_en, flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_dest_reg,
           out_reg_write, out_mem_read, out_mem_write, branch_taken, trap,
           flags
  );
endinterface

// File: rtl/alu_result_stage.sv
// EX/MEM result stage: captures ALU result, flags and control bits through a
// 2-entry skid buffer (main M drives the outputs, skid S absorbs one entry
// during a stall) so that in_ready comes straight from a flop. Evaluates the
// branch condition at accept time, raises a one-cycle trap on signed overflow
// and keeps sticky NZCV flags.
module alu_result_stage #(
  parameter int BUS   = 8,
  parameter int RADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus_if
);

  typedef struct packed {
    logic [BUS-1:0]   result;
    logic [BUS-1:0]   store_data;
    logic [RADDR-1:0] dest_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch_taken;
  } entry_t;

  entry_t     r_m;
  entry_t     r_s;
  logic       r_m_valid;
  logic       r_s_valid;
  logic       r_in_ready;
  logic       r_trap;
  logic [3:0] r_flags;

  logic       w_acc;
  logic       w_trap_hit;
  logic       w_branch;
  logic       w_m_free;
  entry_t     w_new;
  entry_t     w_m_nxt;
  entry_t     w_s_nxt;
  logic       w_m_valid_nxt;
  logic       w_s_valid_nxt;

  assign w_acc      = bus_if.in_valid & r_in_ready & ~bus_if.flush;
  assign w_trap_hit = w_acc & bus_if.trap_en & bus_if.overflow;
  assign w_m_free   = ~r_m_valid | bus_if.out_ready;

  // Branch decision from the incoming entry's own flags
  always_comb begin
    w_branch = 1'b0;
    case (bus_if.branch_cond)
      3'b000: w_branch = 1'b0;
      3'b001: w_branch = bus_if.zero;
      3'b010: w_branch = ~bus_if.zero;
      3'b011: w_branch = bus_if.negative ^ bus_if.overflow;
      3'b100: w_branch = ~(bus_if.negative ^ bus_if.overflow);
      3'b101: w_branch = ~bus_if.cout;
      3'b110: w_branch = bus_if.cout;
      3'b111: w_branch = 1'b1;
      default: w_branch = 1'b0;
    endcase
  end

  // Build the entry to store; a trapping entry loses its architectural writes
  always_comb begin
    w_new              = '0;
    w_new.result       = bus_if.sout;
    w_new.store_data   = bus_if.store_data;
    w_new.dest_reg     = bus_if.dest_reg;
    w_new.reg_write    = bus_if.reg_write & ~w_trap_hit;
    w_new.mem_read     = bus_if.mem_read;
    w_new.mem_write    = bus_if.mem_write & ~w_trap_hit;
    w_new.branch_taken = w_branch;
  end

  // Skid-buffer next state; M is zeroed whenever it goes empty so the
  // output control bits and branch_taken are 0 while out_valid is 0
  always_comb begin
    w_m_nxt       = r_m;
    w_s_nxt       = r_s;
    w_m_valid_nxt = r_m_valid;
    w_s_valid_nxt = r_s_valid;
    if (bus_if.flush) begin
      w_m_nxt       = '0;
      w_m_valid_nxt = 1'b0;
      w_s_valid_nxt = 1'b0;
    end else if (w_m_free) begin
      if (r_s_valid) begin
        w_m_nxt       = r_s;
        w_m_valid_nxt = 1'b1;
        if (w_acc) begin
          w_s_nxt       = w_new;
          w_s_valid_nxt = 1'b1;
        end else begin
          w_s_valid_nxt = 1'b0;
        end
      end else if (w_acc) begin
        w_m_nxt       = w_new;
        w_m_valid_nxt = 1'b1;
      end else begin
        w_m_nxt       = '0;
        w_m_valid_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_s_nxt       = w_new;
      w_s_valid_nxt = 1'b1;
    end
  end

  // Storage, ready, trap pulse and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m        <= '0;
      r_s        <= '0;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_trap     <= 1'b0;
      r_flags    <= 4'b0000;
    end else begin
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_s_valid  <= w_s_valid_nxt;
      r_in_ready <= ~w_s_valid_nxt;
      r_trap     <= w_trap_hit;
      if (w_acc & bus_if.flags_we)
        r_flags <= {bus_if.negative, bus_if.zero, bus_if.cout, bus_if.overflow};
    end
  end

  assign bus_if.in_ready       = r_in_ready;
  assign bus_if.out_valid      = r_m_valid;
  assign bus_if.out_result     = r_m.result;
  assign bus_if.out_store_data = r_m.store_data;
  assign bus_if.out_dest_reg   = r_m.dest_reg;
  assign bus_if.out_reg_write  = r_m.reg_write;
  assign bus_if.out_mem_read   = r_m.mem_read;
  assign bus_if.out_mem_write  = r_m.mem_write;
  assign bus_if.branch_taken   = r_m.branch_taken;
  assign bus_if.trap           = r_trap;
  assign bus_if.flags          = r_flags;

endmodule
